// File: rtl/mini_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_pkg
//  Purpose  : Shared constants, types and helpers for the mini_alu_vga
//             painting block: 640x480@60 Hz timing, 8x8 cell grid geometry,
//             colour encodings and the input-bit map of the button bus.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package mini_alu_pkg;

  // Horizontal timing, in pixel clocks (25 MHz).
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing, in lines.
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [START, END).
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Grid geometry: 8 columns of 80 px, 8 rows of 60 lines.
  localparam logic [9:0] CELL_W   = 10'd80;
  localparam logic [9:0] CELL_H   = 10'd60;
  localparam logic [9:0] BORDER_W = 10'd4;
  localparam int         GRID_DIM = 8;
  localparam int         CELLS    = GRID_DIM * GRID_DIM;

  // Colour bits are {red, green, blue}.
  typedef enum logic [2:0] {
    COL_BLACK   = 3'b000,
    COL_BLUE    = 3'b001,
    COL_GREEN   = 3'b010,
    COL_CYAN    = 3'b011,
    COL_RED     = 3'b100,
    COL_MAGENTA = 3'b101,
    COL_YELLOW  = 3'b110,
    COL_WHITE   = 3'b111
  } colour_e;

  localparam logic [2:0] RESET_COLOUR  = 3'(COL_RED);
  localparam logic [2:0] BORDER_COLOUR = 3'(COL_WHITE);

  // Cursor position; packed as {y, x} it is directly the cell address.
  typedef struct packed {
    logic [2:0] y;
    logic [2:0] x;
  } cursor_t;

  // Bit positions of the user inputs on the internal button bus.
  localparam int IN_EAST   = 0;
  localparam int IN_NORTH  = 1;
  localparam int IN_SOUTH  = 2;
  localparam int IN_WEST   = 3;
  localparam int IN_CENTER = 4;
  localparam int IN_ROT_A  = 5;
  localparam int IN_ROT_B  = 6;
  localparam int IN_WIDTH  = 7;

  // Cell index of a pixel coordinate, by comparison against the cell
  // boundaries rather than a divider (the range is only 0..799).
  function automatic logic [2:0] cell_index(input logic [9:0] pos,
                                            input logic [9:0] size);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < GRID_DIM; i++) begin
      if (pos >= 10'(i) * size) idx = 3'(i);
    end
    return idx;
  endfunction

  // Position of a coordinate inside its own cell.
  function automatic logic [9:0] cell_offset(input logic [9:0] pos,
                                             input logic [2:0] idx,
                                             input logic [9:0] size);
    return pos - ({7'd0, idx} * size);
  endfunction

  // True when an in-cell offset lies in the border band at either edge.
  function automatic logic on_border(input logic [9:0] off,
                                     input logic [9:0] size);
    return (off < BORDER_W) || (off >= size - BORDER_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : 640x480@60 Hz raster generator. Divides the 50 MHz clock to a
//             25 MHz pixel enable and runs the horizontal/vertical counters.
//             Sync and visible outputs are combinational from the counters;
//             the parent registers them alongside the pixel colour.
//  Ports    : clk      in   system clock
//             rst      in   asynchronous active-high reset
//             hcount   out  pixel column 0..799
//             vcount   out  line 0..524
//             hsync_n  out  horizontal sync, active low
//             vsync_n  out  vertical sync, active low
//             visible  out  current counter position is in 640x480
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing
  import mini_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       visible
);

  logic       pix_en;
  logic [9:0] h_q;
  logic [9:0] v_q;

  // pix_en is low on the first clock after reset, so the first counter
  // step happens on the second clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
      h_q    <= 10'd0;
      v_q    <= 10'd0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_q == H_TOTAL - 10'd1) begin
          h_q <= 10'd0;
          if (v_q == V_TOTAL - 10'd1) v_q <= 10'd0;
          else                        v_q <= v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  assign hcount  = h_q;
  assign vcount  = v_q;
  assign hsync_n = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vsync_n = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign visible = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);

endmodule
`default_nettype wire

// File: rtl/mini_alu_vga.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_vga
//  Purpose  : Interactive VGA painting block. Buttons move a cursor over an
//             8x8 grid, the rotary encoder picks one of eight colours and the
//             rotary push paints the cursor cell. The cursor cell is drawn
//             with a 4 px white border band.
//  Ports    : Clock       in   50 MHz system clock
//             Reset       in   asynchronous active-high reset
//             BTN_EAST    in   cursor left
//             BTN_NORTH   in   cursor up
//             BTN_SOUTH   in   cursor down
//             BTN_WEST    in   cursor right
//             ROT_CENTER  in   paint cursor cell
//             ROT_A       in   colour index +1 (rising edge)
//             ROT_B       in   colour index -1 (rising edge)
//             VGA_RED/GREEN/BLUE  out  registered pixel colour
//             VGA_HSYNC   out  registered horizontal sync, active low
//             VGA_VSYNC   out  registered vertical sync, active low
//             SF_DATA     out  {1'b0, selected colour}
//  Revision : 1.0  initial release
// ============================================================================
module mini_alu_vga
  import mini_alu_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BTN_EAST,
  input  logic       BTN_NORTH,
  input  logic       BTN_SOUTH,
  input  logic       BTN_WEST,
  input  logic       ROT_CENTER,
  input  logic       ROT_A,
  input  logic       ROT_B,
  output logic       VGA_RED,
  output logic       VGA_GREEN,
  output logic       VGA_BLUE,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic [3:0] SF_DATA
);

  // --------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer, then rising-edge detect.
  // --------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] raw_in;
  logic [IN_WIDTH-1:0] sync_q1;
  logic [IN_WIDTH-1:0] sync_q2;
  logic [IN_WIDTH-1:0] prev_q;
  logic [IN_WIDTH-1:0] rise;

  assign raw_in = {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_SOUTH, BTN_NORTH, BTN_EAST};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~prev_q;

  // Opposing requests in the same cycle cancel out.
  logic move_left;
  logic move_right;
  logic move_up;
  logic move_down;
  logic colour_inc;
  logic colour_dec;
  logic paint;

  assign move_left  = rise[IN_EAST]  & ~rise[IN_WEST];
  assign move_right = rise[IN_WEST]  & ~rise[IN_EAST];
  assign move_up    = rise[IN_NORTH] & ~rise[IN_SOUTH];
  assign move_down  = rise[IN_SOUTH] & ~rise[IN_NORTH];
  assign colour_inc = rise[IN_ROT_A] & ~rise[IN_ROT_B];
  assign colour_dec = rise[IN_ROT_B] & ~rise[IN_ROT_A];
  assign paint      = rise[IN_CENTER];

  // --------------------------------------------------------------------------
  // Cursor, colour and cell memory. A paint in the same cycle as a move or a
  // colour change stores the old colour at the old position, which falls out
  // of the non-blocking update order.
  // --------------------------------------------------------------------------
  cursor_t    cursor_q;
  logic [2:0] colour_q;
  logic [2:0] cell_mem [CELLS];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cursor_q <= '0;
      colour_q <= RESET_COLOUR;
      for (int i = 0; i < CELLS; i++) cell_mem[i] <= 3'd0;
    end else begin
      if (paint) cell_mem[cursor_q] <= colour_q;

      // Cursor clamps at the grid edges.
      if (move_right && (cursor_q.x != 3'd7))     cursor_q.x <= cursor_q.x + 3'd1;
      else if (move_left && (cursor_q.x != 3'd0)) cursor_q.x <= cursor_q.x - 3'd1;

      if (move_down && (cursor_q.y != 3'd7))      cursor_q.y <= cursor_q.y + 3'd1;
      else if (move_up && (cursor_q.y != 3'd0))   cursor_q.y <= cursor_q.y - 3'd1;

      // Colour index wraps in both directions.
      if (colour_inc)      colour_q <= colour_q + 3'd1;
      else if (colour_dec) colour_q <= colour_q - 3'd1;
    end
  end

  assign SF_DATA = {1'b0, colour_q};

  // --------------------------------------------------------------------------
  // Raster timing.
  // --------------------------------------------------------------------------
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync_n;
  logic       vsync_n;
  logic       visible;

  vga_timing u_timing (
    .clk     (Clock),
    .rst     (Reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .visible (visible)
  );

  // --------------------------------------------------------------------------
  // Pixel mux.
  // --------------------------------------------------------------------------
  logic [2:0] pix_col;
  logic [2:0] pix_row;
  logic [9:0] h_off;
  logic [9:0] v_off;
  logic       at_cursor;
  logic       in_border;
  logic [2:0] pixel;

  always_comb begin
    pix_col   = cell_index(hcount, CELL_W);
    pix_row   = cell_index(vcount, CELL_H);
    h_off     = cell_offset(hcount, pix_col, CELL_W);
    v_off     = cell_offset(vcount, pix_row, CELL_H);
    at_cursor = (pix_col == cursor_q.x) && (pix_row == cursor_q.y);
    in_border = on_border(h_off, CELL_W) || on_border(v_off, CELL_H);
    pixel     = 3'b000;
    if (visible) begin
      if (at_cursor && in_border) pixel = BORDER_COLOUR;
      else                        pixel = cell_mem[{pix_row, pix_col}];
    end
  end

  // Colour and both syncs are registered together so they stay aligned.
  logic [2:0] rgb_q;
  logic       hsync_q;
  logic       vsync_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rgb_q   <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= pixel;
      hsync_q <= hsync_n;
      vsync_q <= vsync_n;
    end
  end

  assign VGA_RED   = rgb_q[2];
  assign VGA_GREEN = rgb_q[1];
  assign VGA_BLUE  = rgb_q[0];
  assign VGA_HSYNC = hsync_q;
  assign VGA_VSYNC = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_vga.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mini_alu_vga
//  Purpose  : Directed self-checking bench for mini_alu_vga. Pixel positions
//             are located by counting clocks from reset release: the output
//             after clock edge k shows pixel p = (k-1)/2 of the frame, with
//             p = vcount*800 + hcount.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mini_alu_vga;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       BTN_EAST = 1'b0, BTN_NORTH = 1'b0, BTN_SOUTH = 1'b0, BTN_WEST = 1'b0;
  logic       ROT_CENTER = 1'b0, ROT_A = 1'b0, ROT_B = 1'b0;
  logic       VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;
  logic [3:0] SF_DATA;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [6:0] M_EAST   = 7'b0000001;
  localparam logic [6:0] M_NORTH  = 7'b0000010;
  localparam logic [6:0] M_SOUTH  = 7'b0000100;
  localparam logic [6:0] M_WEST   = 7'b0001000;
  localparam logic [6:0] M_CENTER = 7'b0010000;
  localparam logic [6:0] M_A      = 7'b0100000;
  localparam logic [6:0] M_B      = 7'b1000000;

  mini_alu_vga dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .BTN_EAST   (BTN_EAST),
    .BTN_NORTH  (BTN_NORTH),
    .BTN_SOUTH  (BTN_SOUTH),
    .BTN_WEST   (BTN_WEST),
    .ROT_CENTER (ROT_CENTER),
    .ROT_A      (ROT_A),
    .ROT_B      (ROT_B),
    .VGA_RED    (VGA_RED),
    .VGA_GREEN  (VGA_GREEN),
    .VGA_BLUE   (VGA_BLUE),
    .VGA_HSYNC  (VGA_HSYNC),
    .VGA_VSYNC  (VGA_VSYNC),
    .SF_DATA    (SF_DATA)
  );

  always #10 Clock = ~Clock;

  // Clock edges since reset release.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [2:0] rgb();
    return {VGA_RED, VGA_GREEN, VGA_BLUE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_SOUTH, BTN_NORTH, BTN_EAST} = v;
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1'b1;
    drive(7'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // Press, check SF_DATA exactly three edges later, then release.
  task automatic press(input logic [6:0] v, input logic [3:0] exp_sf, input string tag);
    drive(v);
    repeat (3) @(posedge Clock);
    #1;
    check(tag, SF_DATA, exp_sf);
    drive(7'd0);
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic wait_edge(input int k);
    if (cyc > k) begin
      checks++;
      failures++;
      $error("FAIL late_sample: observed=%0d expected<=%0d", cyc, k);
    end
    while (cyc < k) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic pix(input int h, input int v, input logic [2:0] exp, input string tag);
    wait_edge(2 * (v * 800 + h) + 1);
    check(tag, rgb(), exp);
  endtask

  initial begin
    int fall1, rise1, fall2, blank_bad, vs_bad;
    logic hs_prev;

    // ---------------- Phase A: reset values, sync timing, empty grid -------
    do_reset();
    check("rst_rgb",   rgb(),     3'b000);
    check("rst_hsync", VGA_HSYNC, 1'b1);
    check("rst_vsync", VGA_VSYNC, 1'b1);
    check("rst_sf",    SF_DATA,   4'b0100);

    fall1 = -1; rise1 = -1; fall2 = -1; blank_bad = 0; vs_bad = 0;
    hs_prev = VGA_HSYNC;
    while (cyc < 5000) begin
      @(posedge Clock);
      #1;
      if (hs_prev && !VGA_HSYNC) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!hs_prev && VGA_HSYNC && rise1 < 0) rise1 = cyc;
      hs_prev = VGA_HSYNC;
      if (((cyc - 1) / 2) % 800 >= 640 && rgb() != 3'b000) blank_bad++;
      if (!VGA_VSYNC) vs_bad++;
      case (cyc)
        1741: check("pix_70_1_border",  rgb(), 3'b111);
        3205: check("pix_2_2_border",   rgb(), 3'b111);
        3401: check("pix_100_2_cell1",  rgb(), 3'b000);
        4959: check("pix_79_3_border",  rgb(), 3'b111);
        4961: check("pix_80_3_cell1",   rgb(), 3'b000);
        default: ;
      endcase
    end
    check("hsync_first_fall", fall1, 1313);
    check("hsync_low_width",  rise1 - fall1, 192);
    check("hsync_period",     fall2 - fall1, 1600);
    check("blank_rgb_zero",   blank_bad, 0);
    check("vsync_stays_high", vs_bad, 0);
    pix(10, 10, 3'b000, "pix_10_10_interior");

    // ---------------- Phase B: colour, moves, painting ----------------------
    do_reset();
    // Latency: no change after two edges, update on the third.
    drive(M_A);
    repeat (2) @(posedge Clock);
    #1;
    check("rot_a_lat2", SF_DATA, 4'b0100);
    @(posedge Clock);
    #1;
    check("rot_a_1", SF_DATA, 4'b0101);
    drive(7'd0);
    repeat (3) @(posedge Clock);
    #1;
    press(M_A, 4'b0110, "rot_a_2");
    press(M_A, 4'b0111, "rot_a_3");
    press(M_A, 4'b0000, "rot_a_wrap");
    press(M_B, 4'b0111, "rot_b_wrap");
    press(M_A | M_B, 4'b0111, "rot_ab_cancel");
    for (int i = 0; i < 5; i++) press(M_B, 4'(6 - i), "rot_b_dn");
    press(M_WEST,   4'b0010, "w1");
    press(M_WEST,   4'b0010, "w2");
    press(M_CENTER, 4'b0010, "paint_2_0");
    press(M_WEST,   4'b0010, "w3");
    press(M_CENTER | M_A | M_WEST, 4'b0011, "paint_move_inc");
    press(M_CENTER, 4'b0011, "paint_4_0");
    press(M_EAST | M_WEST,   4'b0011, "ew_cancel");
    press(M_NORTH | M_SOUTH, 4'b0011, "ns_cancel");
    press(M_A,      4'b0100, "rot_a_red");
    press(M_CENTER, 4'b0100, "repaint_4_0");
    press(M_SOUTH,  4'b0100, "s1");

    pix(330, 2,  3'b100, "b_pix_330_2_no_border");
    pix(10,  10, 3'b000, "b_pix_cell0");
    pix(200, 10, 3'b010, "b_pix_cell2");
    pix(280, 10, 3'b010, "b_pix_cell3_pre_colour");
    pix(360, 10, 3'b100, "b_pix_cell4");
    pix(440, 10, 3'b000, "b_pix_cell5");
    pix(700, 10, 3'b000, "b_pix_blank");
    pix(200, 11, 3'b010, "b_pix_cell2_l11");
    wait_edge(2 * (11 * 800 + 700) + 1);
    check("hsync_low_mid", VGA_HSYNC, 1'b0);
    Reset = 1'b1;
    #1;
    check("midrst_hsync", VGA_HSYNC, 1'b1);
    check("midrst_vsync", VGA_VSYNC, 1'b1);
    check("midrst_rgb",   rgb(),     3'b000);
    check("midrst_sf",    SF_DATA,   4'b0100);

    // ---------------- Phase C: cleared memory, clamping ---------------------
    do_reset();
    press(M_NORTH | M_EAST, 4'b0100, "ne_clamp");
    press(M_CENTER,         4'b0100, "paint_0_0");
    for (int i = 0; i < 9; i++) press(M_WEST, 4'b0100, "w_clamp");
    press(M_CENTER,         4'b0100, "paint_7_0");

    pix(600, 2,  3'b111, "c_pix_cell7_top_border");
    pix(2,   10, 3'b100, "c_pix_cell0_edge");
    pix(40,  10, 3'b100, "c_pix_cell0");
    pix(200, 10, 3'b000, "c_pix_cell2_cleared");
    pix(280, 10, 3'b000, "c_pix_cell3_cleared");
    pix(360, 10, 3'b000, "c_pix_cell4_cleared");
    pix(562, 10, 3'b111, "c_pix_cell7_left_border");
    pix(600, 10, 3'b100, "c_pix_cell7");
    pix(637, 10, 3'b111, "c_pix_cell7_right_border");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
